pipo_bank_buffer: RTL and testbench

Multi-bank parallel-in/parallel-out vector buffer for the img2col path. It holds up to BANKS full-width vectors of REG_NUM lanes in a circular order. A valid/ready handshake on both sides lets the img2col writer fill one bank while the PE-array reader drains another (ping-pong at BANKS=2). It replaces single-register PIPO staging wherever writer and reader run decoupled.

---
 rtl/pipo_pkg.sv | 15 +
 rtl/pipo_bank_buffer_if.sv | 38 +++
 rtl/pipo_bank.sv | 40 ++++
 rtl/pipo_bank_buffer.sv | 76 +++++++
 tb/tb_pipo_bank_buffer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipo_pkg.sv
// Shared constants, lane type and pointer helper for the multi-bank PIPO vector buffer.
package pipo_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefRegNum    = 20;
  localparam int unsigned DefBanks     = 2;

  typedef logic [DefDataWidth-1:0] lane_t;

  // Wraps at banks-1 so non-power-of-two bank counts work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned banks);
    return (ptr >= banks - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipo_bank_buffer_if.sv
// Writer/reader handshake bundle for pipo_bank_buffer.
// PIPO_LANE_MASK_EN adds the wr_lane_cnt lane-count input.
interface pipo_bank_buffer_if import pipo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned REG_NUM    = DefRegNum,
  parameter int unsigned BANKS      = DefBanks
) ();

  logic                          wr_valid;
  logic                          wr_ready;
  logic [DATA_WIDTH-1:0]         wr_data [REG_NUM];
  logic                          rd_valid;
  logic                          rd_ready;
  logic [DATA_WIDTH-1:0]         rd_data [REG_NUM];
  logic [$clog2(BANKS+1)-1:0]    count;
`ifdef PIPO_LANE_MASK_EN
  logic [$clog2(REG_NUM+1)-1:0]  wr_lane_cnt;

  modport slave (
    input  wr_valid, wr_data, wr_lane_cnt, rd_ready,
    output wr_ready, rd_valid, rd_data, count
  );
  modport master (
    output wr_valid, wr_data, wr_lane_cnt, rd_ready,
    input  wr_ready, rd_valid, rd_data, count
  );
`else
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count
  );
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count
  );
`endif

endinterface

// File: rtl/pipo_bank.sv
// One REG_NUM-lane vector register with write enable.
// PIPO_LANE_MASK_EN zero-fills lanes at or above i_lane_cnt on write.
module pipo_bank import pipo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned REG_NUM    = DefRegNum
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_data [REG_NUM],
`ifdef PIPO_LANE_MASK_EN
  input  logic [$clog2(REG_NUM+1)-1:0] i_lane_cnt,
`endif
  output logic [DATA_WIDTH-1:0] o_data [REG_NUM]
);

  logic [DATA_WIDTH-1:0] r_lanes [REG_NUM];
  logic [DATA_WIDTH-1:0] w_next  [REG_NUM];

  always_comb begin
    for (int i = 0; i < int'(REG_NUM); i++) begin
`ifdef PIPO_LANE_MASK_EN
      w_next[i] = (32'(i_lane_cnt) > i) ? i_data[i] : '0;
`else
      w_next[i] = i_data[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(REG_NUM); i++) r_lanes[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < int'(REG_NUM); i++) r_lanes[i] <= w_next[i];
    end
  end

  assign o_data = r_lanes;

endmodule

// File: rtl/pipo_bank_buffer.sv
// Circular multi-bank vector buffer with valid/ready on both sides (ping-pong at BANKS=2).
// Optional PIPO_LANE_MASK_EN enables per-write lane-count zero padding.
module pipo_bank_buffer import pipo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned REG_NUM    = DefRegNum,
  parameter int unsigned BANKS      = DefBanks
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            clear,
  pipo_bank_buffer_if.slave bus
);

  localparam int unsigned PtrW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned CntW = $clog2(BANKS + 1);

  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [BANKS-1:0]      w_bank_we;
  logic [DATA_WIDTH-1:0] w_bank_data [BANKS][REG_NUM];

  // Ready depends on occupancy only: no write pass-through when full.
  assign bus.wr_ready = (r_count != CntW'(BANKS));
  assign bus.rd_valid = (r_count != '0);
  assign bus.count    = r_count;
  assign w_wr_fire    = bus.wr_valid & bus.wr_ready;
  assign w_rd_fire    = bus.rd_valid & bus.rd_ready;

  always_comb begin
    w_bank_we = '0;
    if (w_wr_fire && !clear) w_bank_we[r_wr_ptr] = 1'b1;
  end

  for (genvar g = 0; g < int'(BANKS); g++) begin : g_bank
    pipo_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_NUM    (REG_NUM)
    ) u_bank (
      .clk        (clk),
      .nrst       (nrst),
      .i_we       (w_bank_we[g]),
      .i_data     (bus.wr_data),
`ifdef PIPO_LANE_MASK_EN
      .i_lane_cnt (bus.wr_lane_cnt),
`endif
      .o_data     (w_bank_data[g])
    );
  end

  always_comb begin
    for (int i = 0; i < int'(REG_NUM); i++) begin
      bus.rd_data[i] = bus.rd_valid ? w_bank_data[r_rd_ptr][i] : '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= PtrW'(ptr_inc(32'(r_wr_ptr), BANKS));
      if (w_rd_fire) r_rd_ptr <= PtrW'(ptr_inc(32'(r_rd_ptr), BANKS));
      if (w_wr_fire && !w_rd_fire)      r_count <= r_count + 1'b1;
      else if (w_rd_fire && !w_wr_fire) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipo_bank_buffer.sv
// Scoreboard bench for pipo_bank_buffer: a FIFO-queue model predicts every output each cycle.
// Build with PIPO_LANE_MASK_EN to also exercise lane-count zero padding.
module tb_pipo_bank_buffer;
  import pipo_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned RN = 4;
  localparam int unsigned NB = 2;

  typedef lane_t vec_t [RN];

  logic clk   = 1'b0;
  logic nrst  = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  pipo_bank_buffer_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .BANKS(NB)) bif ();

  pipo_bank_buffer #(
    .DATA_WIDTH (DW),
    .REG_NUM    (RN),
    .BANKS      (NB)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .bus   (bif.slave)
  );

  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  vec_t m_v;
  vec_t mon_exp;
  vec_t mon_act;
  bit   m_rf;
  bit   m_wf;

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = lane_t'(a); v[1] = lane_t'(b); v[2] = lane_t'(c); v[3] = lane_t'(d);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a bounded FIFO of vectors; clear empties it.
  always @(posedge clk) begin
    if (nrst) begin
      if (clear) begin
        exp_q.delete();
      end else begin
        m_rf = (exp_q.size() != 0) && bif.rd_ready;
        m_wf = (exp_q.size() < NB) && bif.wr_valid;
        for (int i = 0; i < int'(RN); i++) begin
`ifdef PIPO_LANE_MASK_EN
          m_v[i] = (i < int'(bif.wr_lane_cnt)) ? bif.wr_data[i] : '0;
`else
          m_v[i] = bif.wr_data[i];
`endif
        end
        if (m_rf) void'(exp_q.pop_front());
        if (m_wf) exp_q.push_back(m_v);
      end
    end
  end

  // Monitor: compares every visible output against the model mid-cycle.
  always @(negedge clk) begin
    if (!done) begin
      check("wr_ready", int'(bif.wr_ready), int'(exp_q.size() != NB));
      check("rd_valid", int'(bif.rd_valid), int'(exp_q.size() != 0));
      check("count", int'(bif.count), exp_q.size());
      for (int i = 0; i < int'(RN); i++) begin
        mon_act[i] = bif.rd_data[i];
        mon_exp[i] = (exp_q.size() != 0) ? exp_q[0][i] : '0;
      end
      checks++;
      if (mon_act != mon_exp) begin
        errors++;
        $display("FAIL rd_data: got %p, expected %p at %0t", mon_act, mon_exp, $time);
      end
    end
  end

  task automatic drive(input bit wv, input vec_t d, input bit rr, input bit clr, input int lc);
    bif.wr_valid = wv;
    for (int i = 0; i < int'(RN); i++) bif.wr_data[i] = d[i];
    bif.rd_ready = rr;
    clear        = clr;
`ifdef PIPO_LANE_MASK_EN
    bif.wr_lane_cnt = 3'(lc);
`else
    if (lc < 0) $display("negative lane count ignored");
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t z, v;
    z = mk(0, 0, 0, 0);
    bif.wr_valid = 1'b0;
    bif.rd_ready = 1'b0;
    for (int i = 0; i < int'(RN); i++) bif.wr_data[i] = '0;
`ifdef PIPO_LANE_MASK_EN
    bif.wr_lane_cnt = 3'd4;
`endif
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (2) drive(0, z, 0, 0, 4);

    // Single write, then held while reader stalls.
    drive(1, mk(1, 2, 3, 4), 0, 0, 4);
    repeat (5) drive(0, z, 0, 0, 4);
    drive(0, z, 1, 0, 4);

    // Fill to full, third write must be ignored, then drain.
    drive(1, mk(1, 2, 3, 4), 0, 0, 4);
    drive(1, mk(5, 6, 7, 8), 0, 0, 4);
    drive(1, mk(9, 9, 9, 9), 0, 0, 4);
    drive(0, z, 1, 0, 4);
    drive(0, z, 1, 0, 4);
    drive(0, z, 0, 0, 4);

    // Full with both sides active, then continuous streaming across pointer wraps.
    drive(1, mk(10, 11, 12, 13), 0, 0, 4);
    drive(1, mk(14, 15, 16, 17), 0, 0, 4);
    for (int k = 0; k < 10; k++) drive(1, mk(20 + k, 30 + k, 40 + k, 50 + k), 1, 0, 4);
    repeat (3) drive(0, z, 1, 0, 4);

    // Clear while full overrides a concurrent write.
    drive(1, mk(60, 61, 62, 63), 0, 0, 4);
    drive(1, mk(64, 65, 66, 67), 0, 0, 4);
    drive(1, mk(68, 69, 70, 71), 0, 1, 4);
    repeat (2) drive(0, z, 1, 0, 4);

`ifdef PIPO_LANE_MASK_EN
    drive(1, mk(7, 7, 7, 7), 0, 0, 2);
    drive(0, z, 1, 0, 4);
    drive(1, mk(7, 7, 7, 7), 0, 0, 0);
    drive(0, z, 1, 0, 4);
    drive(1, mk(3, 4, 5, 6), 0, 0, 7);
    drive(0, z, 1, 0, 4);
`endif

    // Asynchronous reset mid-operation drops stored vectors.
    drive(1, mk(80, 81, 82, 83), 0, 0, 4);
    drive(1, mk(84, 85, 86, 87), 0, 0, 4);
    nrst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 nrst = 1'b1;
    drive(0, z, 0, 0, 4);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < int'(RN); i++) v[i] = lane_t'($urandom);
      drive(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0), int'($urandom_range(0, 5)));
    end
    repeat (3) drive(0, z, 1, 0, 4);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
